// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the fetch/load requesters, the shared ROM and the arbiter.
// The master side is the environment (core + ROM); the slave side is the arbiter.
interface rom_port_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             if_err;

  logic             d_req;
  logic [WIDTH-1:0] d_addr;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             d_err;

  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output if_req, if_addr, d_req, d_addr, rom_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  rom_addr, conflict_cnt
  );

  modport slave (
    input  if_req, if_addr, d_req, d_addr, rom_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output rom_addr, conflict_cnt
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between instruction fetch
// and data load; one access per cycle, registered response one cycle later.
module rom_port_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  rom_port_arbiter_if.slave bus
);

  localparam logic [WIDTH-1:0] LEN_LIMIT = WIDTH'(LENGTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef struct packed {
    logic             rvalid;
    logic             err;
    logic [WIDTH-1:0] rdata;
  } rsp_t;

  logic             last_d,   last_d_nxt;
  rsp_t             if_rsp,   if_rsp_nxt;
  rsp_t             d_rsp,    d_rsp_nxt;
  logic [CNT_W-1:0] cnt,      cnt_nxt;

  logic             gnt_if;
  logic             gnt_d;
  logic             both_req;
  logic [WIDTH-1:0] gnt_addr;
  logic             addr_ok;

  // Arbitration: a lone requester wins; on contention the port not served last wins.
  always_comb begin
    both_req = bus.if_req & bus.d_req;
    gnt_d    = bus.d_req & (~bus.if_req | ~last_d);
    gnt_if   = bus.if_req & ~gnt_d;
    gnt_addr = gnt_d ? bus.d_addr : bus.if_addr;
    addr_ok  = (gnt_addr[1:0] == 2'b00) &&
               ({2'b00, gnt_addr[WIDTH-1:2]} < LEN_LIMIT);
  end

  assign bus.if_gnt   = gnt_if;
  assign bus.d_gnt    = gnt_d;
  assign bus.rom_addr = ((gnt_if | gnt_d) && addr_ok) ? gnt_addr : '0;

  // Next-state: pointer, per-port response capture and saturating contention count.
  always_comb begin
    last_d_nxt        = last_d;
    if_rsp_nxt        = if_rsp;
    d_rsp_nxt         = d_rsp;
    cnt_nxt           = cnt;
    if_rsp_nxt.rvalid = 1'b0;
    d_rsp_nxt.rvalid  = 1'b0;

    if (gnt_if | gnt_d) begin
      last_d_nxt = gnt_d;
    end

    if (gnt_if) begin
      if_rsp_nxt.rvalid = 1'b1;
      if_rsp_nxt.err    = ~addr_ok;
      if_rsp_nxt.rdata  = addr_ok ? bus.rom_data : '0;
    end

    if (gnt_d) begin
      d_rsp_nxt.rvalid = 1'b1;
      d_rsp_nxt.err    = ~addr_ok;
      d_rsp_nxt.rdata  = addr_ok ? bus.rom_data : '0;
    end

    if (both_req && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Reset drops any grant made in the same cycle and hands the first contention to fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b1;
      if_rsp <= '0;
      d_rsp  <= '0;
      cnt    <= '0;
    end else begin
      last_d <= last_d_nxt;
      if_rsp <= if_rsp_nxt;
      d_rsp  <= d_rsp_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign bus.if_rvalid    = if_rsp.rvalid;
  assign bus.if_err       = if_rsp.err;
  assign bus.if_rdata     = if_rsp.rdata;
  assign bus.d_rvalid     = d_rsp.rvalid;
  assign bus.d_err        = d_rsp.err;
  assign bus.d_rdata      = d_rsp.rdata;
  assign bus.conflict_cnt = cnt;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural ROM and hand-computed expectations.
module tb_rom_port_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LENGTH = 1024;
  localparam int unsigned CNT_W  = 16;

  logic clk;
  logic rst_n;

  rom_port_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  rom_port_arbiter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] rom_mem [0:LENGTH-1];
  assign bus.rom_data = rom_mem[bus.rom_addr[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_addr  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(LENGTH); i++) rom_mem[i] = 32'h0;
    rom_mem[0] = 32'h0000_0013;
    rom_mem[3] = 32'h0050_0093;
    rom_mem[4] = 32'hDEAD_BEEF;

    // Reset then idle
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    chk("rst_if_err",    32'(bus.if_err),    32'h0);
    chk("rst_d_err",     32'(bus.d_err),     32'h0);
    chk("rst_if_rdata",  bus.if_rdata,       32'h0);
    chk("rst_d_rdata",   bus.d_rdata,        32'h0);
    chk("rst_cnt",       32'(bus.conflict_cnt), 32'h0);
    chk("rst_rom_addr",  bus.rom_addr,       32'h0);
    chk("rst_gnts",      32'({bus.if_gnt, bus.d_gnt}), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rvalids", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
    end

    // Single fetch of word 3
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0C;
    #1;
    chk("fetch_if_gnt",   32'(bus.if_gnt), 32'h1);
    chk("fetch_d_gnt",    32'(bus.d_gnt),  32'h0);
    chk("fetch_rom_addr", bus.rom_addr,    32'h0C);
    tick();
    bus.if_req = 1'b0;
    chk("fetch_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("fetch_rdata",  bus.if_rdata,       32'h0050_0093);
    chk("fetch_err",    32'(bus.if_err),    32'h0);
    chk("fetch_d_quiet", 32'(bus.d_rvalid), 32'h0);
    tick();
    chk("fetch_pulse_end", 32'(bus.if_rvalid), 32'h0);
    chk("fetch_rdata_hold", bus.if_rdata, 32'h0050_0093);

    // Contention from reset: if, d, if, d
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
      if ((k % 2) == 0) begin
        chk("cont_gnt_if", 32'({bus.if_gnt, bus.d_gnt}), 32'h2);
        chk("cont_addr_if", bus.rom_addr, 32'h0);
      end else begin
        chk("cont_gnt_d", 32'({bus.if_gnt, bus.d_gnt}), 32'h1);
        chk("cont_addr_d", bus.rom_addr, 32'h10);
      end
      tick();
      if ((k % 2) == 0) begin
        chk("cont_rsp_if", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h2);
        chk("cont_rdata_if", bus.if_rdata, 32'h0000_0013);
      end else begin
        chk("cont_rsp_d", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h1);
        chk("cont_rdata_d", bus.d_rdata, 32'hDEAD_BEEF);
      end
    end
    idle_inputs();
    chk("cont_cnt", 32'(bus.conflict_cnt), 32'h4);

    // Fetch at 0 (pointer -> fetch), then misaligned load (pointer -> load)
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    tick();
    idle_inputs();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h6;
    #1;
    chk("mis_d_gnt",    32'(bus.d_gnt),  32'h1);
    chk("mis_rom_addr", bus.rom_addr,    32'h0);
    tick();
    idle_inputs();
    chk("mis_rvalid", 32'(bus.d_rvalid), 32'h1);
    chk("mis_err",    32'(bus.d_err),    32'h1);
    chk("mis_rdata",  bus.d_rdata,       32'h0);
    // Contention now must go to fetch if the pointer moved to load
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0C;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h10;
    #1;
    chk("mis_ptr_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'h2);
    tick();
    idle_inputs();
    chk("mis_ptr_rdata", bus.if_rdata, 32'h0050_0093);
    chk("cnt_five", 32'(bus.conflict_cnt), 32'h5);

    // Out of range fetch then in-range fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1000;
    #1;
    chk("oor_gnt",      32'(bus.if_gnt), 32'h1);
    chk("oor_rom_addr", bus.rom_addr,    32'h0);
    tick();
    bus.if_addr = 32'h0;
    chk("oor_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("oor_err",    32'(bus.if_err),    32'h1);
    chk("oor_rdata",  bus.if_rdata,       32'h0);
    chk("oor_d_err_hold", 32'(bus.d_err), 32'h1);
    tick();
    idle_inputs();
    chk("inr_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("inr_err",    32'(bus.if_err),    32'h0);
    chk("inr_rdata",  bus.if_rdata,       32'h0000_0013);

    // Reset asserted in the same cycle a load is granted
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h10;
    rst_n      = 1'b0;
    #1;
    chk("rmid_d_gnt", 32'(bus.d_gnt), 32'h1);
    tick();
    rst_n = 1'b1;
    chk("rmid_no_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rmid_cnt",       32'(bus.conflict_cnt), 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    #1;
    chk("rmid_if_first", 32'({bus.if_gnt, bus.d_gnt}), 32'h2);
    tick();
    idle_inputs();
    chk("rmid_cnt_one", 32'(bus.conflict_cnt), 32'h1);
    chk("rmid_if_rsp",  32'({bus.if_rvalid, bus.d_rvalid}), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
